morse_tx: RTL and testbench



---
 rtl/morse_pkg.sv | 37 +++
 rtl/morse_tx_unit_timer.sv | 29 ++
 rtl/morse_tx.sv | 96 +++++++++
 tb/tb_morse_tx.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared Morse definitions: default element count, unit multiples
// for marks and gaps, transmitter state encoding and a unit lookup.
package morse_pkg;

   localparam int MAX_SYM_DEF = 5;

   localparam logic [2:0] DOT_UNITS  = 3'd1;
   localparam logic [2:0] DASH_UNITS = 3'd3;
   localparam logic [2:0] EGAP_UNITS = 3'd1;
   localparam logic [2:0] LGAP_UNITS = 3'd3;
   localparam logic [2:0] WGAP_UNITS = 3'd7;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MARK = 3'd1,
      EGAP = 3'd2,
      LGAP = 3'd3,
      WGAP = 3'd4,
      DONE = 3'd5
   } tx_state_e;

   // Number of units a state lasts; dash selects the mark length.
   function automatic logic [2:0] units_for(input tx_state_e s,
                                            input logic dash);
      logic [2:0] u;
      u = 3'd0;
      case (s)
         MARK:    u = dash ? DASH_UNITS : DOT_UNITS;
         EGAP:    u = EGAP_UNITS;
         LGAP:    u = LGAP_UNITS;
         WGAP:    u = WGAP_UNITS;
         default: u = 3'd0;
      endcase
      return u;
   endfunction

endpackage

// File: rtl/morse_tx_unit_timer.sv
// Mod-UNIT_TICKS cycle counter producing one tick per Morse unit.
// Ports: clk, reset_n (async low), clear (restart count), tick (terminal count).
module unit_timer #(
   parameter int UNIT_TICKS = 5_000_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   output logic tick
);

   localparam int W = (UNIT_TICKS > 1) ? $clog2(UNIT_TICKS) : 1;
   localparam logic [W-1:0] LAST = W'(UNIT_TICKS - 1);

   logic [W-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear || tick) cnt_d = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

endmodule

// File: rtl/morse_tx.sv
// Morse transmitter: accepts a dot/dash pattern and keys it with unit timing.
// Ports: clk, reset_n, start/sym_len/sym_bits in; ready, key, done out.
module morse_tx
   import morse_pkg::*;
#(
   parameter int UNIT_TICKS = 5_000_000,
   parameter int MAX_SYM    = MAX_SYM_DEF
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [2:0]         sym_len,
   input  logic [MAX_SYM-1:0] sym_bits,
   output logic               ready,
   output logic               key,
   output logic               done
);

   tx_state_e          state_q, state_d;
   logic [MAX_SYM-1:0] pat_q, pat_d;
   logic [2:0]         elems_q, elems_d;
   logic [2:0]         units_q, units_d;
   logic               key_q, done_q;
   logic               tick, entry, last_unit;
   logic [2:0]         len_c;

   assign len_c = (sym_len > 3'(MAX_SYM)) ? 3'(MAX_SYM) : sym_len;
   assign last_unit = tick && (units_q == 3'd1);

   unit_timer #(.UNIT_TICKS(UNIT_TICKS)) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (entry),
      .tick    (tick)
   );

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      elems_d = elems_q;
      units_d = units_q;
      if (tick && units_q != 3'd0) units_d = units_q - 3'd1;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               pat_d   = sym_bits;
               elems_d = len_c;
               state_d = (len_c != 3'd0) ? MARK : WGAP;
            end else begin
               state_d = IDLE;
            end
         end
         MARK: begin
            if (last_unit) begin
               if (elems_q == 3'd1) begin
                  state_d = LGAP;
               end else begin
                  state_d = EGAP;
                  elems_d = elems_q - 3'd1;
                  pat_d   = pat_q >> 1;
               end
            end
         end
         EGAP: if (last_unit) state_d = MARK;
         LGAP: if (last_unit) state_d = DONE;
         WGAP: if (last_unit) state_d = DONE;
         default: state_d = IDLE;
      endcase
      entry = (state_d != state_q);
      // pat_d[0] is already the element the next mark will send.
      if (entry) units_d = units_for(state_d, pat_d[0]);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         pat_q   <= '0;
         elems_q <= '0;
         units_q <= '0;
         key_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         elems_q <= elems_d;
         units_q <= units_d;
         key_q   <= (state_d == MARK);
         done_q  <= (state_d == DONE);
      end
   end

   assign key   = key_q;
   assign done  = done_q;
   assign ready = (state_q == IDLE) || (state_q == DONE);

endmodule

// File: tb/tb_morse_tx.sv
// Self-checking bench for morse_tx with UNIT_TICKS=4.
// Expected key waveforms come from a timing-rule model built into queues.
module tb_morse_tx;

   localparam int U = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic [2:0] sym_len = '0;
   logic [4:0] sym_bits = '0;
   logic       ready, key, done;

   int checks = 0;
   int failures = 0;
   bit exp_key[$];

   morse_tx #(.UNIT_TICKS(U), .MAX_SYM(5)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .sym_len  (sym_len),
      .sym_bits (sym_bits),
      .ready    (ready),
      .key      (key),
      .done     (done)
   );

   always #5 clk = ~clk;

   // Key level for every cycle from 1 up to (not incl.) the done cycle.
   task automatic model_char(input int len, input logic [4:0] bits);
      int n;
      n = (len > 5) ? 5 : len;
      exp_key.delete();
      if (n == 0) begin
         repeat (7 * U) exp_key.push_back(1'b0);
      end else begin
         for (int i = 0; i < n; i++) begin
            repeat ((bits[i] ? 3 : 1) * U) exp_key.push_back(1'b1);
            repeat ((i == n - 1 ? 3 : 1) * U) exp_key.push_back(1'b0);
         end
      end
   endtask

   // Caller is at a negedge; sends one char and checks every cycle.
   task automatic run_char(input string name, input int len,
                           input logic [4:0] bits, input bit noise);
      int n;
      bit ek;
      model_char(len, bits);
      n = exp_key.size() + 1;
      checks++;
      if (ready !== 1'b1) begin
         failures++;
         $display("FAIL %s ready_before_start got=%b want=1", name, ready);
      end
      start = 1'b1;
      sym_len = 3'(len);
      sym_bits = bits;
      @(posedge clk);
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         start = (noise && c < n) ? 1'($urandom_range(0, 1)) : 1'b0;
         if (noise) begin
            sym_len = 3'($urandom_range(0, 7));
            sym_bits = 5'($urandom);
         end
         ek = (c < n) ? exp_key[c-1] : 1'b0;
         checks++;
         if (key !== ek) begin
            failures++;
            $display("FAIL %s key cyc=%0d got=%b want=%b", name, c, key, ek);
         end
         checks++;
         if (done !== (c == n)) begin
            failures++;
            $display("FAIL %s done cyc=%0d got=%b want=%b",
                     name, c, done, (c == n));
         end
         checks++;
         if (ready !== (c == n)) begin
            failures++;
            $display("FAIL %s ready cyc=%0d got=%b want=%b",
                     name, c, ready, (c == n));
         end
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      #3;
      checks++;
      if (key !== 1'b0 || done !== 1'b0 || ready !== 1'b1) begin
         failures++;
         $display("FAIL reset got key=%b done=%b ready=%b want 0 0 1",
                  key, done, ready);
      end
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_e_idle;
      run_char("E", 1, 5'b00000, 1'b0);
      repeat (3) @(negedge clk);
      checks++;
      if (ready !== 1'b1 || done !== 1'b0 || key !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_E got ready=%b done=%b key=%b want 1 0 0",
                  ready, done, key);
      end
   endtask

   task automatic test_a;
      @(negedge clk);
      run_char("A", 2, 5'b00010, 1'b0);
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      run_char("SPACE", 0, 5'b00000, 1'b0);
      run_char("T_b2b", 1, 5'b00001, 1'b0);
   endtask

   task automatic test_ignore_start;
      @(negedge clk);
      run_char("O_noise", 3, 5'b00111, 1'b1);
   endtask

   task automatic test_clamp;
      @(negedge clk);
      run_char("CLAMP7", 7, 5'b11111, 1'b0);
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      start = 1'b1;
      sym_len = 3'd1;
      sym_bits = 5'b00001;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (key !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid key_before got=%b want=1", key);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (key !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid async got key=%b done=%b want 0 0", key, done);
      end
      @(negedge clk);
      reset_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (ready !== 1'b1 || done !== 1'b0 || key !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid after cyc=%0d got ready=%b done=%b key=%b want 1 0 0",
                     c, ready, done, key);
         end
         @(negedge clk);
      end
      run_char("E_after_rst", 1, 5'b00000, 1'b0);
   endtask

   task automatic test_random;
      int len;
      logic [4:0] bits;
      bit noise;
      for (int k = 0; k < 8; k++) begin
         len = $urandom_range(0, 7);
         bits = 5'($urandom);
         noise = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 0) @(negedge clk);
         run_char("RAND", len, bits, noise);
      end
   endtask

   initial begin
      test_reset();
      test_e_idle();
      test_a();
      test_back_to_back();
      test_ignore_start();
      test_clamp();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
